// File: rtl/slink_apb_master.sv
// APB4 requester: buffers commands in a small FIFO, runs one APB access at a time,
// and holds each result in a single response slot until the consumer accepts it.
module slink_apb_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                    apb_clk,
    input  logic                    apb_reset,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,

    output logic [ADDR_WIDTH-1:0]   apb_paddr,
    output logic                    apb_pwrite,
    output logic                    apb_psel,
    output logic                    apb_penable,
    output logic [DATA_WIDTH-1:0]   apb_pwdata,
    output logic [DATA_WIDTH/8-1:0] apb_pstrb,
    input  logic [DATA_WIDTH-1:0]   apb_prdata,
    input  logic                    apb_pready,
    input  logic                    apb_pslverr,

    output logic                    busy,
    output logic [7:0]              err_count
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(CMD_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    logic                  fifo_write_q [CMD_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q  [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata_q [CMD_DEPTH];
    logic [STRB_W-1:0]     fifo_strb_q  [CMD_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  cmd_ready_q;

    state_t                state_q;
    logic                  psel_q;
    logic                  penable_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_W-1:0]     pstrb_q;
    logic [WAIT_W-1:0]     wait_q;

    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;
    logic [7:0]            err_count_q;

    logic                  push;
    logic                  pop;
    logic                  head_write;
    logic                  timeout_hit;
    logic                  cpl_err;

    assign push        = cmd_valid && cmd_ready_q;
    // A new access only starts once the previous response has been consumed.
    assign pop         = (state_q == IDLE) && (count_q != '0) && !rsp_valid_q;
    assign head_write  = fifo_write_q[rd_ptr_q];
    assign timeout_hit = (TIMEOUT != 0) && !apb_pready && (wait_q == WAIT_LAST);
    assign cpl_err     = apb_pready ? apb_pslverr : 1'b1;

    always_comb begin
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge apb_clk) begin
        if (push) begin
            fifo_write_q[wr_ptr_q] <= cmd_write;
            fifo_addr_q[wr_ptr_q]  <= cmd_addr;
            fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
            fifo_strb_q[wr_ptr_q]  <= cmd_strb;
        end
    end

    // cmd_ready is registered from the next-state occupancy so it reads as !full.
    always_ff @(posedge apb_clk) begin
        if (apb_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q     <= count_d;
            cmd_ready_q <= (count_d != FULL_CNT);
        end
    end

    always_ff @(posedge apb_clk) begin
        if (apb_reset) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            wait_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        paddr_q  <= fifo_addr_q[rd_ptr_q];
                        pwrite_q <= head_write;
                        pwdata_q <= head_write ? fifo_wdata_q[rd_ptr_q] : '0;
                        pstrb_q  <= head_write ? fifo_strb_q[rd_ptr_q] : '0;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A late pready on the timeout edge still wins.
                    if (apb_pready || timeout_hit) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= cpl_err;
                        rsp_timeout_q <= !apb_pready;
                        rsp_rdata_q   <= (apb_pready && !pwrite_q) ? apb_prdata : '0;
                        if (cpl_err && (err_count_q != 8'hFF)) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign apb_paddr   = paddr_q;
    assign apb_pwrite  = pwrite_q;
    assign apb_psel    = psel_q;
    assign apb_penable = penable_q;
    assign apb_pwdata  = pwdata_q;
    assign apb_pstrb   = pstrb_q;
    assign err_count   = err_count_q;
    assign busy        = (count_q != '0) || (state_q != IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_slink_apb_master.sv
// Bench for slink_apb_master: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized traffic phase.
module tb_slink_apb_master;

    localparam int TO    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cv = 1'b0, cw = 1'b0;
    logic [7:0]  ca = '0;
    logic [31:0] cd = '0;
    logic [3:0]  cs = '0;
    logic        rr = 1'b0;
    logic [31:0] prd = '0;
    logic        prdy = 1'b0, pslv = 1'b0;
    logic        cr, rv, re, rt, pw, ps, pe, bsy;
    logic [31:0] rd, pd;
    logic [7:0]  pa, ec;
    logic [3:0]  pst;

    slink_apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CMD_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .apb_clk(clk), .apb_reset(rst),
        .cmd_valid(cv), .cmd_ready(cr), .cmd_write(cw), .cmd_addr(ca), .cmd_wdata(cd), .cmd_strb(cs),
        .rsp_valid(rv), .rsp_ready(rr), .rsp_rdata(rd), .rsp_err(re), .rsp_timeout(rt),
        .apb_paddr(pa), .apb_pwrite(pw), .apb_psel(ps), .apb_penable(pe), .apb_pwdata(pd), .apb_pstrb(pst),
        .apb_prdata(prd), .apb_pready(prdy), .apb_pslverr(pslv),
        .busy(bsy), .err_count(ec)
    );

    // Second instance with the timeout disabled.
    logic        r1 = 1'b1, cv1 = 1'b0, cw1 = 1'b0, rr1 = 1'b0, prdy1 = 1'b0;
    logic [7:0]  ca1 = '0;
    logic        cr1, rv1, re1, rt1, pw1, ps1, pe1, bsy1;
    logic [31:0] rd1, pd1;
    logic [7:0]  pa1, ec1;
    logic [3:0]  pst1;

    slink_apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CMD_DEPTH(DEPTH), .TIMEOUT(0)) dut_nto (
        .apb_clk(clk), .apb_reset(r1),
        .cmd_valid(cv1), .cmd_ready(cr1), .cmd_write(cw1), .cmd_addr(ca1), .cmd_wdata(32'h0), .cmd_strb(4'h0),
        .rsp_valid(rv1), .rsp_ready(rr1), .rsp_rdata(rd1), .rsp_err(re1), .rsp_timeout(rt1),
        .apb_paddr(pa1), .apb_pwrite(pw1), .apb_psel(ps1), .apb_penable(pe1), .apb_pwdata(pd1), .apb_pstrb(pst1),
        .apb_prdata(32'h0), .apb_pready(prdy1), .apb_pslverr(1'b0),
        .busy(bsy1), .err_count(ec1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
    } cmd_t;

    cmd_t        mq[$];
    cmd_t        mc;
    bit          m_started = 0;
    int          m_phase = 0;   // 0 no access, 1 setup cycle, 2 access cycles
    int          m_waits = 0;
    logic        m_rdy = 0, m_psel = 0, m_pen = 0, m_write = 0;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_strb = '0;
    logic        m_rv = 0, m_err = 0, m_to = 0;
    logic [31:0] m_rdata = '0;
    logic [7:0]  m_errc = '0;
    int          old_phase, old_n;
    logic        old_rv, acc_now;

    task automatic m_finish(input logic err, input logic [31:0] data, input logic to);
        m_psel = 0; m_pen = 0; m_phase = 0;
        m_rv = 1; m_err = err; m_rdata = data; m_to = to;
        if (err && m_errc != 8'd255) m_errc = 8'(m_errc + 8'd1);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1;
            mq.delete();
            m_phase = 0; m_waits = 0; m_rdy = 0; m_psel = 0; m_pen = 0; m_write = 0;
            m_addr = '0; m_wdata = '0; m_strb = '0;
            m_rv = 0; m_err = 0; m_to = 0; m_rdata = '0; m_errc = '0;
        end else if (m_started) begin
            old_phase = m_phase;
            old_rv    = m_rv;
            old_n     = mq.size();
            acc_now   = cv && m_rdy;
            if (m_rv && rr) m_rv = 0;
            if (old_phase == 0) begin
                if (old_n > 0 && !old_rv) begin
                    mc = mq.pop_front();
                    m_psel = 1; m_phase = 1;
                    m_addr = mc.a; m_write = mc.w;
                    m_wdata = mc.w ? mc.d : 32'h0;
                    m_strb = mc.w ? mc.s : 4'h0;
                end
            end else if (old_phase == 1) begin
                m_pen = 1; m_waits = 0; m_phase = 2;
            end else begin
                if (prdy) m_finish(pslv, m_write ? 32'h0 : prd, 1'b0);
                else if (TO != 0 && m_waits + 1 == TO) m_finish(1'b1, 32'h0, 1'b1);
                else m_waits++;
            end
            if (acc_now) mq.push_back('{w: cw, a: ca, d: cd, s: cs});
            m_rdy = (mq.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("cmd_ready", 64'(cr), 64'(m_rdy));
            chk("psel", 64'(ps), 64'(m_psel));
            chk("penable", 64'(pe), 64'(m_pen));
            chk("penable_without_psel", 64'(pe && !ps), 64'(0));
            chk("rsp_valid", 64'(rv), 64'(m_rv));
            chk("err_count", 64'(ec), 64'(m_errc));
            chk("busy", 64'(bsy), 64'((mq.size() != 0) || (m_phase != 0) || m_rv));
            if (m_psel) begin
                chk("paddr", 64'(pa), 64'(m_addr));
                chk("pwrite", 64'(pw), 64'(m_write));
                chk("pwdata", 64'(pd), 64'(m_wdata));
                chk("pstrb", 64'(pst), 64'(m_strb));
            end
            if (m_rv) begin
                chk("rsp_rdata", 64'(rd), 64'(m_rdata));
                chk("rsp_err", 64'(re), 64'(m_err));
                chk("rsp_timeout", 64'(rt), 64'(m_to));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; cv = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    int  acc;
    int  resp;
    logic was;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rr = 1'b1; prdy = 1'b1;
        repeat (2) tick();
        chk("rst_cmd_ready", 64'(cr), 64'(0));
        chk("rst_psel", 64'(ps), 64'(0));
        chk("rst_penable", 64'(pe), 64'(0));
        chk("rst_paddr", 64'(pa), 64'(0));
        chk("rst_pwdata", 64'(pd), 64'(0));
        chk("rst_pstrb", 64'(pst), 64'(0));
        chk("rst_pwrite", 64'(pw), 64'(0));
        chk("rst_rsp", 64'({rv, re, rt}), 64'(0));
        chk("rst_rdata", 64'(rd), 64'(0));
        chk("rst_err_count", 64'(ec), 64'(0));
        chk("rst_busy", 64'(bsy), 64'(0));
        rst = 1'b0;
        tick();
        chk("ready_after_reset", 64'(cr), 64'(1));

        // Zero-wait write, latency pinned
        cv = 1; cw = 1; ca = 8'h10; cd = 32'hDEADBEEF; cs = 4'hF;
        tick(); cv = 0;
        chk("w_E_psel", 64'(ps), 64'(0));
        tick();
        chk("w_E1_psel", 64'({ps, pe}), 64'(2'b10));
        chk("w_E1_fields", 64'({pa, pd, pst}), 64'({8'h10, 32'hDEADBEEF, 4'hF}));
        tick();
        chk("w_E2_penable", 64'({ps, pe}), 64'(2'b11));
        tick();
        chk("w_E3_rsp", 64'({rv, re, rt, ps, pe}), 64'(5'b10000));
        chk("w_E3_rdata", 64'(rd), 64'(0));
        repeat (3) tick();

        // Read with 3 wait states
        prdy = 0; cv = 1; cw = 0; ca = 8'h24; cd = 32'hFFFF0000; cs = 4'hF;
        tick(); cv = 0;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            chk("r_penable_held", 64'({pe, pst}), 64'({1'b1, 4'h0}));
            tick();
        end
        chk("r_penable_held", 64'({pe, pst}), 64'({1'b1, 4'h0}));
        prdy = 1; prd = 32'h12345678;
        tick();
        chk("r_rsp", 64'({rv, re, pe}), 64'(3'b100));
        chk("r_rdata", 64'(rd), 64'(32'h12345678));
        repeat (3) tick();

        // Timeout after 8 wait cycles, then late pready on the timeout edge
        do_reset();
        rr = 0; prdy = 0; pslv = 0;
        cv = 1; cw = 1; ca = 8'h40; cd = 32'h0BADF00D; cs = 4'h3;
        tick(); cv = 0;
        repeat (2) tick();
        repeat (7) tick();
        chk("to_pending", 64'({rv, pe}), 64'(2'b01));
        tick();
        chk("to_rsp", 64'({rv, re, rt, ps}), 64'(4'b1110));
        chk("to_rdata", 64'(rd), 64'(0));
        chk("to_err_count", 64'(ec), 64'(1));
        rr = 1; tick(); rr = 0;
        cv = 1; cw = 0; ca = 8'h44;
        tick(); cv = 0;
        repeat (2) tick();
        repeat (7) tick();
        chk("late_pending", 64'({rv, pe}), 64'(2'b01));
        prdy = 1; prd = 32'hA5A5A5A5;
        tick();
        chk("late_rsp", 64'({rv, re, rt}), 64'(3'b100));
        chk("late_rdata", 64'(rd), 64'(32'hA5A5A5A5));
        chk("late_err_count", 64'(ec), 64'(1));
        rr = 1; tick();

        // Five back-to-back commands with the response path stalled
        do_reset();
        rr = 0; prdy = 1; pslv = 0; acc = 0;
        cv = 1;
        for (int i = 0; i < 20 && acc < 5; i++) begin
            cw = 0; ca = 8'(8'h80 + acc);
            was = cr;
            tick();
            if (was) acc++;
        end
        cv = 0;
        chk("bb_accepted", 64'(acc), 64'(5));
        chk("bb_full", 64'(cr), 64'(0));
        for (int i = 0; i < 5; i++) begin
            chk("bb_stalled", 64'({ps, rv}), 64'(2'b01));
            tick();
        end
        rr = 1;
        tick();
        chk("bb_no_setup_on_accept", 64'({ps, rv}), 64'(2'b00));
        tick();
        chk("bb_setup_after", 64'(ps), 64'(1));
        resp = 1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rv) resp++;
        end
        chk("bb_responses", 64'(resp), 64'(5));
        chk("bb_idle", 64'(bsy), 64'(0));

        // Randomized traffic: mostly-ready slave, then a slow slave to provoke timeouts
        for (int i = 0; i < 3000; i++) begin
            cv = ($urandom_range(0, 1) == 1);
            cw = 1'($urandom); ca = 8'($urandom); cd = $urandom; cs = 4'($urandom);
            rr = ($urandom_range(0, 9) < 6);
            prdy = (i < 2000) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) < 3);
            pslv = ($urandom_range(0, 9) < 2);
            prd = $urandom;
            tick();
        end
        cv = 0;

        // Error counter saturation
        do_reset();
        rr = 1; prdy = 1; pslv = 1; acc = 0;
        cv = 1;
        for (int i = 0; i < 3000 && acc < 300; i++) begin
            cw = 1'($urandom); ca = 8'($urandom); cd = $urandom; cs = 4'($urandom);
            was = cr;
            tick();
            if (was) acc++;
        end
        cv = 0;
        for (int i = 0; i < 50 && bsy; i++) tick();
        chk("sat_accepted", 64'(acc), 64'(300));
        chk("sat_idle", 64'(bsy), 64'(0));
        chk("sat_err_count", 64'(ec), 64'(255));

        // Reset in the middle of an access with two commands queued
        rr = 1; prdy = 0; pslv = 0;
        cv = 1; cw = 1;
        for (int k = 0; k < 3; k++) begin
            ca = 8'(8'hC0 + k);
            tick();
        end
        cv = 0;
        chk("mid_in_access", 64'({ps, pe}), 64'(2'b11));
        rst = 1;
        tick();
        chk("mid_rst_outputs", 64'({ps, pe, rv, bsy, cr}), 64'(0));
        chk("mid_rst_err_count", 64'(ec), 64'(0));
        rst = 0;
        tick();
        chk("mid_release", 64'({cr, bsy, ps}), 64'(3'b100));
        repeat (3) tick();
        chk("mid_discarded", 64'({ps, rv, bsy}), 64'(0));

        // Timeout disabled: access stays pending
        r1 = 1; tick(); r1 = 0; tick();
        cv1 = 1; cw1 = 0; ca1 = 8'h33; prdy1 = 0;
        tick(); cv1 = 0;
        repeat (1000) tick();
        chk("nto_pending", 64'({ps1, pe1, rv1, bsy1}), 64'(4'b1101));
        chk("nto_paddr", 64'(pa1), 64'(8'h33));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
